mul_issue_sequencer: RTL and testbench

//  Front-end for the sequential 32x32 shift-add multiplier; it sits directly upstream of it.
//  - Accepts operand pairs on a valid/ready channel and buffers them in a small FIFO.
//  - Loads each pair into the multiplier, pulses a run request and waits for its Ready.
//  - Captures the 64-bit product and presents it on a valid/ready result channel.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_op_fifo.sv | 82 ++++++++
 rtl/mul_issue_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mul_issue_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue sequencer: operand width,
// sequencer state encoding and the product type.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        HOLD = 3'd4
    } mul_state_e;

    typedef logic [2*MUL_WIDTH-1:0] mul_product_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Small synchronous FIFO holding operand pairs ahead of the multiplier.
// The head entry is visible combinationally so the multiplier operands can
// be driven straight from it. The "ready" flag is registered and stays low
// until the first clock after reset release.
module mul_op_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          ready
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A pop on the same cycle frees the slot, so a full FIFO may still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign ready   = ready_q;

    // Next-state for pointers, occupancy and the registered not-full flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        ready_d = (count_d != FULL_CNT);
    end

    // Pointer and flag registers; storage contents need no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // One write port per entry, selected by the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q == AW'(gi))) begin
                mem[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/mul_issue_sequencer.sv
// Front-end for the sequential shift-add multiplier. Operand pairs are
// buffered in a FIFO, issued one at a time (load pulse, then run until the
// multiplier reports ready), and the product is held on a valid/ready
// result channel. Only one product is ever outstanding.
// Optional feature macro: MUL_TIMEOUT_EN adds a RUN watchdog that drops the
// stuck entry and raises a sticky Err.
module mul_issue_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH,
    parameter int DEPTH   = 4
`ifdef MUL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 40
`endif
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [WIDTH-1:0]   In_Multiplicand,
    input  logic [WIDTH-1:0]   In_Multiplier,
    output logic [WIDTH-1:0]   Mul_Multiplicand,
    output logic [WIDTH-1:0]   Mul_Multiplier,
    output logic               Mul_Load,
    output logic               Mul_Run,
    input  logic               Mul_Ready,
    input  logic [2*WIDTH-1:0] Mul_Product,
    output logic               Res_Valid,
    input  logic               Res_Ready,
    output logic [2*WIDTH-1:0] Res_Product,
    output logic               Busy,
    output logic               Err
);

    logic [2*WIDTH-1:0] fifo_head;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    mul_state_e         state_q, state_d;
    logic               mul_load_q, mul_load_d;
    logic               mul_run_q, mul_run_d;
    logic               run_first_q, run_first_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] res_product_q, res_product_d;

`ifdef MUL_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
`endif

    assign push = In_Valid && In_Ready;

    mul_op_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (Reset),
        .push      (push),
        .push_data ({In_Multiplicand, In_Multiplier}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .ready     (In_Ready)
    );

    // Head operands go straight to the multiplier; forced to zero when the
    // FIFO is empty so nothing undefined leaks out of reset.
    assign Mul_Multiplicand = fifo_empty ? '0 : fifo_head[2*WIDTH-1:WIDTH];
    assign Mul_Multiplier   = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
    assign Mul_Load         = mul_load_q;
    assign Mul_Run          = mul_run_q;
    assign Res_Valid        = res_valid_q;
    assign Res_Product      = res_product_q;
    assign Busy             = (state_q != IDLE) || !fifo_empty;
`ifdef MUL_TIMEOUT_EN
    assign Err              = err_q;
`else
    assign Err              = 1'b0;
`endif

    // Sequencer next-state; Mul_Load/Mul_Run are computed for the state being
    // entered so that they come out of flops aligned with LOAD/RUN.
    always_comb begin
        state_d       = state_q;
        mul_load_d    = 1'b0;
        mul_run_d     = 1'b0;
        run_first_d   = run_first_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        pop           = 1'b0;
`ifdef MUL_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = LOAD;
                    mul_load_d = 1'b1;
                end
            end
            LOAD: begin
                state_d     = RUN;
                mul_run_d   = 1'b1;
                run_first_d = 1'b1;
`ifdef MUL_TIMEOUT_EN
                tmo_cnt_d   = '0;
`endif
            end
            RUN: begin
                mul_run_d   = 1'b1;
                run_first_d = 1'b0;
`ifdef MUL_TIMEOUT_EN
                tmo_cnt_d   = tmo_cnt_q + TW'(1);
`endif
                // The done flag may still be left over from the previous
                // operation during the first RUN cycle, so it is not trusted.
                if (!run_first_q && Mul_Ready) begin
                    state_d   = CAPT;
                    mul_run_d = 1'b0;
                end
`ifdef MUL_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    mul_run_d = 1'b0;
                    err_d     = 1'b1;
                    pop       = 1'b1;
                end
`endif
            end
            CAPT: begin
                state_d       = HOLD;
                res_product_d = Mul_Product;
                res_valid_d   = 1'b1;
                pop           = 1'b1;
            end
            HOLD: begin
                if (Res_Ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            mul_load_q    <= 1'b0;
            mul_run_q     <= 1'b0;
            run_first_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
`ifdef MUL_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mul_load_q    <= mul_load_d;
            mul_run_q     <= mul_run_d;
            run_first_q   <= run_first_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
`ifdef MUL_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_issue_sequencer.sv
// Bench for mul_issue_sequencer: a behavioural shift-add multiplier stand-in
// answers Mul_Load/Mul_Run, directed operand pairs are pushed with their
// hand-computed products queued, and a monitor checks each result handshake.
module tb_mul_issue_sequencer;
    import mul_pkg::*;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic          In_Ready;
    logic [W-1:0]  In_Multiplicand;
    logic [W-1:0]  In_Multiplier;
    logic [W-1:0]  Mul_Multiplicand;
    logic [W-1:0]  Mul_Multiplier;
    logic          Mul_Load;
    logic          Mul_Run;
    logic          Mul_Ready;
    logic [2*W-1:0] Mul_Product;
    logic          Res_Valid;
    logic          Res_Ready;
    logic [2*W-1:0] Res_Product;
    logic          Busy;
    logic          Err;

    int total = 0;
    int bad   = 0;
    mul_product_t exp_q[$];
    mul_product_t mon_exp;
    int load_cnt = 0;

    bit stall      = 1'b0;
    bit stale_mode = 1'b0;
    logic [W-1:0] m_a, m_b;
    int   m_cnt;
    logic m_pend;

    always #5 clk = ~clk;

    mul_issue_sequencer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk              (clk),
        .Reset            (Reset),
        .In_Valid         (In_Valid),
        .In_Ready         (In_Ready),
        .In_Multiplicand  (In_Multiplicand),
        .In_Multiplier    (In_Multiplier),
        .Mul_Multiplicand (Mul_Multiplicand),
        .Mul_Multiplier   (Mul_Multiplier),
        .Mul_Load         (Mul_Load),
        .Mul_Run          (Mul_Run),
        .Mul_Ready        (Mul_Ready),
        .Mul_Product      (Mul_Product),
        .Res_Valid        (Res_Valid),
        .Res_Ready        (Res_Ready),
        .Res_Product      (Res_Product),
        .Busy             (Busy),
        .Err              (Err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Multiplier stand-in: latches operands on load, raises a sticky done
    // flag LAT run cycles later. In stale mode the old done flag survives
    // into the first run cycle.
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Mul_Ready   <= 1'b0;
            Mul_Product <= '0;
            m_cnt       <= 0;
            m_pend      <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
        end else if (Mul_Load) begin
            m_a    <= Mul_Multiplicand;
            m_b    <= Mul_Multiplier;
            m_cnt  <= 0;
            m_pend <= stale_mode;
            if (!stale_mode) Mul_Ready <= 1'b0;
        end else if (Mul_Run) begin
            if (m_pend) begin
                Mul_Ready <= 1'b0;
                m_pend    <= 1'b0;
            end
            if (!stall && m_cnt < LAT) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == LAT - 1) begin
                    Mul_Ready   <= 1'b1;
                    Mul_Product <= {32'b0, m_a} * {32'b0, m_b};
                end
            end
        end
    end

    // Result monitor: every accepted result is compared with the queue head.
    always @(negedge clk) begin
        if (Reset === 1'b1 && Res_Valid === 1'b1 && Res_Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%h required=none", Res_Product);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("txn result act=%h exp=%h", Res_Product, mon_exp);
                chk("result", Res_Product, mon_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (Mul_Load === 1'b1) load_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input mul_product_t e, input bit expect_res);
        int g = 0;
        while (In_Ready !== 1'b1 && g < 300) begin
            tick();
            g++;
        end
        if (In_Ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_wait actual=In_Ready_low required=In_Ready_high");
        end else begin
            In_Valid        = 1'b1;
            In_Multiplicand = a;
            In_Multiplier   = b;
            if (expect_res) exp_q.push_back(e);
            $display("txn push a=%h b=%h", a, b);
            tick();
            In_Valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || Busy !== 1'b0) && g < 600) begin
            tick();
            g++;
        end
        chk(name, 64'(exp_q.size()) | 64'(Busy !== 1'b0), 64'd0);
    endtask

    task automatic wait_ready(input string name);
        int g = 0;
        while (Mul_Ready !== 1'b1 && g < 300) begin
            tick();
            g++;
        end
        chk(name, 64'(Mul_Ready), 64'd1);
    endtask

    initial begin
        int lc;
        int n;
        bit stable;

        Reset           = 1'b0;
        In_Valid        = 1'b0;
        In_Multiplicand = '0;
        In_Multiplier   = '0;
        Res_Ready       = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready",    64'(In_Ready),  64'd0);
        chk("rst_mul_load",    64'(Mul_Load),  64'd0);
        chk("rst_mul_run",     64'(Mul_Run),   64'd0);
        chk("rst_res_valid",   64'(Res_Valid), 64'd0);
        chk("rst_res_product", Res_Product,    64'd0);
        chk("rst_busy",        64'(Busy),      64'd0);
        chk("rst_err",         64'(Err),       64'd0);
        chk("rst_mul_a",       64'(Mul_Multiplicand), 64'd0);
        Reset = 1'b1;
        #1;
        chk("in_ready_before_clk", 64'(In_Ready), 64'd0);
        tick();
        chk("in_ready_after_clk", 64'(In_Ready), 64'd1);

        // Single operation with latency checks
        push(32'd3, 32'd5, 64'd15, 1'b1);
        chk("t1_load_not_yet", 64'(Mul_Load), 64'd0);
        chk("t1_busy",         64'(Busy),     64'd1);
        tick();
        chk("t1_load_pulse",   64'(Mul_Load), 64'd1);
        chk("t1_head_a",       64'(Mul_Multiplicand), 64'd3);
        chk("t1_head_b",       64'(Mul_Multiplier),   64'd5);
        tick();
        chk("t1_load_end",     64'(Mul_Load), 64'd0);
        chk("t1_run",          64'(Mul_Run),  64'd1);
        wait_ready("t1_mul_ready_seen");
        chk("t1_res_valid_c0", 64'(Res_Valid), 64'd0);
        tick();
        chk("t1_res_valid_c1", 64'(Res_Valid), 64'd0);
        chk("t1_run_dropped",  64'(Mul_Run),   64'd0);
        tick();
        chk("t1_res_valid_c2", 64'(Res_Valid), 64'd1);
        chk("t1_res_product",  Res_Product,    64'd15);
        drain("t1_drain");

        // Burst against a stalled multiplier
        stall = 1'b1;
        push(32'd2,  32'd3,  64'd6,  1'b1);
        push(32'd4,  32'd5,  64'd20, 1'b1);
        push(32'd6,  32'd7,  64'd42, 1'b1);
        push(32'd8,  32'd9,  64'd72, 1'b1);
        chk("t2_full_in_ready", 64'(In_Ready), 64'd0);
        chk("t2_head_a",        64'(Mul_Multiplicand), 64'd2);
        repeat (3) tick();
        chk("t2_still_full",    64'(In_Ready), 64'd0);
        stall = 1'b0;
        push(32'd10, 32'd11, 64'd110, 1'b1);
        drain("t2_drain");

        // Result backpressure
        Res_Ready = 1'b0;
        push(32'd7,  32'd9,  64'd63,  1'b1);
        push(32'd12, 32'd11, 64'd132, 1'b1);
        n = 0;
        while (Res_Valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t3_res_valid", 64'(Res_Valid), 64'd1);
        lc = load_cnt;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (Res_Valid !== 1'b1 || Res_Product !== 64'd63) stable = 1'b0;
        end
        chk("t3_product_stable", 64'(stable), 64'd1);
        chk("t3_no_new_load",    64'(load_cnt - lc), 64'd0);
        chk("t3_busy",           64'(Busy), 64'd1);
        Res_Ready = 1'b1;
        drain("t3_drain");

        // Operand extremes
        push(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);
        push(32'h00000000, 32'h12345678, 64'h0,                1'b1);
        push(32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 1'b1);
        push(32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b1);
        drain("t4_drain");

        // Done flag still high from the previous op during the first RUN cycle
        stale_mode = 1'b1;
        push(32'd10, 32'd10, 64'd100, 1'b1);
        drain("stale_drain");
        stale_mode = 1'b0;

        // Reset pulled low while an op is in RUN and another is queued
        stall = 1'b1;
        push(32'd5, 32'd5, 64'd25, 1'b0);
        push(32'd6, 32'd6, 64'd36, 1'b0);
        n = 0;
        while (Mul_Run !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_in_run", 64'(Mul_Run), 64'd1);
        tick();
        Reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_run",       64'(Mul_Run),   64'd0);
        chk("t5_rst_load",      64'(Mul_Load),  64'd0);
        chk("t5_rst_res_valid", 64'(Res_Valid), 64'd0);
        chk("t5_rst_product",   Res_Product,    64'd0);
        chk("t5_rst_busy",      64'(Busy),      64'd0);
        chk("t5_rst_in_ready",  64'(In_Ready),  64'd0);
        chk("t5_rst_mul_a",     64'(Mul_Multiplicand), 64'd0);
        stall = 1'b0;
        tick();
        Reset = 1'b1;
        lc = load_cnt;
        tick();
        chk("t5_in_ready_back", 64'(In_Ready), 64'd1);
        repeat (5) tick();
        chk("t5_fifo_empty",    64'(Busy),      64'd0);
        chk("t5_no_stale_res",  64'(Res_Valid), 64'd0);
        chk("t5_no_load",       64'(load_cnt - lc), 64'd0);
        push(32'd9, 32'd9, 64'd81, 1'b1);
        drain("t5_drain");

`ifdef MUL_TIMEOUT_EN
        // Watchdog: first op never completes, the next one must
        stall = 1'b1;
        push(32'd2, 32'd2, 64'd4,  1'b0);
        push(32'd6, 32'd7, 64'd42, 1'b1);
        n = 0;
        while (Mul_Run !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (Mul_Run === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_run_cycles", 64'(n),   64'd40);
        chk("t6_err",        64'(Err), 64'd1);
        stall = 1'b0;
        drain("t6_drain");
        chk("t6_err_sticky", 64'(Err), 64'd1);
`else
        chk("err_tied_low", 64'(Err), 64'd0);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
